// File: rtl/div_const_share_arb.sv
// Round-robin shared front end for a combinational divide-by-constant core: operand register,
// tagged result register, one backpressured response channel. Optional checker: DIV_CHECK_EN.
module div_const_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned X_W     = 16,
  parameter int unsigned Q_W     = 15,
  parameter int unsigned R_W     = 2,
  parameter int unsigned DIVISOR = 3,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [X_W-1:0]         div_x,
  input  logic [Q_W-1:0]         div_q,
  input  logic [R_W-1:0]         div_r,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [Q_W-1:0]         rsp_q,
  output logic [R_W-1:0]         rsp_r,
  output logic                   busy,
  output logic                   chk_err
);

  logic            s1_valid_q;
  logic [ID_W-1:0] s1_id_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_next;
  logic            s1_adv, s2_adv;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [X_W-1:0]  grant_x;
  logic [ID_W:0]   cand;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign busy   = s1_valid_q || rsp_valid;

  // Search upward from rr_ptr with wrap; no grant while the pipeline is blocked or in reset.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_x     = '0;
    cand        = '0;
    req_ready   = '0;
    if (s1_adv && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
        if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[ID_W-1:0];
        end
      end
    end
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
      grant_x = req_x[int'(grant_idx)*X_W +: X_W];
    end
  end

  always_comb begin
    rr_next = grant_idx + ID_W'(1);
    if (grant_idx == ID_W'(NUM_REQ - 1)) rr_next = '0;
  end

  // Stage 1: operand register feeding the divider core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      div_x      <= '0;
      rr_ptr_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= grant_found;
      if (grant_found) begin
        div_x    <= grant_x;
        s1_id_q  <= grant_idx;
        rr_ptr_q <= rr_next;
      end
    end
  end

  // Stage 2: tagged result register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_id <= s1_id_q;
        rsp_q  <= div_q;
        rsp_r  <= div_r;
      end
    end
  end

`ifdef DIV_CHECK_EN
  logic [X_W+1:0] chk_sum;
  logic           chk_bad;

  assign chk_sum = (X_W+2)'(DIVISOR) * (X_W+2)'(div_q) + (X_W+2)'(div_r);
  assign chk_bad = (chk_sum != (X_W+2)'(div_x)) || (32'(div_r) >= DIVISOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (s2_adv && s1_valid_q && chk_bad) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_const_share_arb.sv
// Bench for div_const_share_arb: directed stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares each response handshake.
module tb_div_const_share_arb;

  localparam int N = 4;

`ifdef DIV_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*16-1:0] req_x = '0;
  logic [N-1:0]  req_ready;
  logic [15:0]   div_x;
  logic [14:0]   div_q;
  logic [1:0]    div_r;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [1:0]    rsp_id;
  logic [14:0]   rsp_q;
  logic [1:0]    rsp_r;
  logic          busy;
  logic          chk_err;
  logic          inject = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [14:0] q;
    logic [1:0]  r;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;

  always #5 clk = ~clk;

  // Divider core model; inject forces an off-by-one quotient for x == 9.
  always_comb begin
    div_q = 15'(div_x / 16'd3);
    div_r = 2'(div_x % 16'd3);
    if (inject && div_x == 16'd9) div_q = div_q + 15'd1;
  end

  div_const_share_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .div_x     (div_x),
    .div_q     (div_q),
    .div_r     (div_r),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .busy      (busy),
    .chk_err   (chk_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [14:0] q, input logic [1:0] r);
    exp_q.push_back('{id: id, q: q, r: r});
  endtask

  task automatic set_x(input int i, input logic [15:0] v);
    req_x[i*16 +: 16] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: a response handshake completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_q", 32'(rsp_q), 32'(mon_e.q));
        chk("rsp_r", 32'(rsp_r), 32'(mon_e.r));
      end
    end
  end

  logic [3:0] bp_grant [5];

  initial begin
    // Reset values.
    #2;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_div_x", 32'(div_x), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_q", 32'(rsp_q), 0);
    chk("rst_rsp_r", 32'(rsp_r), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_chk_err", 32'(chk_err), 0);
    step();
    rst_n = 1'b1;
    step();

    // Single request: 100 / 3 = 33 r 1, response one cycle after accept.
    set_x(0, 16'd100);
    req_valid = 4'b0001;
    #0;
    chk("single_grant", 32'(req_ready), 32'b0001);
    push(2'd0, 15'd33, 2'd1);
    step();
    req_valid = '0;
    chk("single_s1_rsp_valid", 32'(rsp_valid), 0);
    chk("single_div_x", 32'(div_x), 100);
    chk("single_busy", 32'(busy), 1);
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    drain();

    // Fairness from a fresh pointer: grants 0,1,2,3,0,1,2,3.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_x(0, 16'd300);
    set_x(1, 16'd100);
    set_x(2, 16'hFFFF);
    set_x(3, 16'd5);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #0;
      chk("fair_grant", 32'(req_ready), 32'(1) << (k % 4));
      case (k % 4)
        0: push(2'd0, 15'd100, 2'd0);
        1: push(2'd1, 15'd33, 2'd1);
        2: push(2'd2, 15'd21845, 2'd0);
        default: push(2'd3, 15'd1, 2'd2);
      endcase
      step();
    end
    req_valid = '0;
    drain();

    // Backpressure: three requesters, consumer stalled five cycles.
    bp_grant[0] = 4'b0001;
    bp_grant[1] = 4'b0010;
    bp_grant[2] = 4'b0000;
    bp_grant[3] = 4'b0000;
    bp_grant[4] = 4'b0000;
    set_x(0, 16'd7);
    set_x(1, 16'd8);
    set_x(2, 16'd1000);
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      #0;
      chk("bp_grant", 32'(req_ready), 32'(bp_grant[k]));
      if (k == 0) push(2'd0, 15'd2, 2'd1);
      if (k == 1) push(2'd1, 15'd2, 2'd2);
      if (k >= 2) begin
        chk("bp_hold_valid", 32'(rsp_valid), 1);
        chk("bp_hold_id", 32'(rsp_id), 0);
        chk("bp_hold_q", 32'(rsp_q), 2);
      end
      step();
      req_valid = req_valid & ~bp_grant[k];
    end
    rsp_ready = 1'b1;
    #0;
    chk("bp_resume_grant", 32'(req_ready), 32'b0100);
    push(2'd2, 15'd333, 2'd1);
    step();
    req_valid = '0;
    drain();

    // Wrap/skip: pointer at 3, only requester 1 valid; pointer then at 2.
    set_x(1, 16'd50);
    req_valid = 4'b0010;
    #0;
    chk("skip_grant", 32'(req_ready), 32'b0010);
    push(2'd1, 15'd16, 2'd2);
    step();
    set_x(2, 16'd30);
    req_valid = 4'b1111;
    #0;
    chk("ptr_after_skip", 32'(req_ready), 32'b0100);
    push(2'd2, 15'd10, 2'd0);
    step();
    req_valid = '0;
    drain();

    // Faulty core result for x = 9; response is delivered as produced.
    inject = 1'b1;
    set_x(3, 16'd9);
    req_valid = 4'b1000;
    #0;
    chk("chk_grant", 32'(req_ready), 32'b1000);
    push(2'd3, 15'd4, 2'd0);
    step();
    req_valid = '0;
    step();
    chk("chk_err_capture", 32'(chk_err), 32'(EXP_CHK));
    inject = 1'b0;
    drain();
    step();
    step();
    chk("chk_err_sticky", 32'(chk_err), 32'(EXP_CHK));

    // Reset with both stages full; in-flight items are dropped.
    set_x(0, 16'd300);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #0;
    chk("mid_grant0", 32'(req_ready), 32'b0001);
    step();
    chk("mid_grant1", 32'(req_ready), 32'b0010);
    step();
    chk("mid_full_grant", 32'(req_ready), 0);
    chk("mid_full_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_div_x", 32'(div_x), 0);
    chk("mid_rst_rsp_q", 32'(rsp_q), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_chk_err", 32'(chk_err), 0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #0;
    chk("post_rst_grant", 32'(req_ready), 32'b0001);
    push(2'd0, 15'd100, 2'd0);
    step();
    req_valid = '0;
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
